// File: rtl/pwm_meter.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Latency: valid 4 clk edges after the first edge sampling pwm=1 (2 sync, 1 detect, 1 output).
// Backpressure: none; valid is a one-cycle pulse that must be consumed when it appears.
module pwm_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high,
    output logic             valid,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    localparam logic [WIDTH-1:0] CMAX = '1;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pcnt, pcnt_nxt, hcnt, hcnt_nxt;
    logic [WIDTH-1:0] period_nxt, high_nxt;
    logic             valid_nxt, ovf_nxt;
    logic [WIDTH-1:0] pcnt_inc, hcnt_inc;
    logic             sync1, sync2, prev, rise, fall;

    // Edge flags are registered so the FSM always acts one edge after detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pwm;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
            fall  <= ~sync2 & prev;
        end
    end

    assign pcnt_inc = (pcnt == CMAX) ? pcnt : pcnt + ONE;
    assign hcnt_inc = (hcnt == CMAX) ? hcnt : hcnt + ONE;

    always_comb begin
        state_nxt  = state;
        pcnt_nxt   = pcnt;
        hcnt_nxt   = hcnt;
        period_nxt = period;
        high_nxt   = high;
        valid_nxt  = 1'b0;
        ovf_nxt    = ovf;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM: begin
                    if (rise) begin
                        pcnt_nxt  = ONE;
                        hcnt_nxt  = ONE;
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        pcnt_nxt  = pcnt_inc;
                        state_nxt = LOW;
                    end else if (pcnt == CMAX) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = ARM;
                    end else begin
                        pcnt_nxt = pcnt_inc;
                        hcnt_nxt = hcnt_inc;
                    end
                end
                LOW: begin
                    // An edge arriving exactly at saturation still closes a valid period.
                    if (rise) begin
                        period_nxt = pcnt;
                        high_nxt   = hcnt;
                        valid_nxt  = 1'b1;
                        ovf_nxt    = 1'b0;
                        pcnt_nxt   = ONE;
                        hcnt_nxt   = ONE;
                        state_nxt  = HIGH;
                    end else if (pcnt == CMAX) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = ARM;
                    end else begin
                        pcnt_nxt = pcnt_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pcnt   <= '0;
            hcnt   <= '0;
            period <= '0;
            high   <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            pcnt   <= pcnt_nxt;
            hcnt   <= hcnt_nxt;
            period <= period_nxt;
            high   <= high_nxt;
            valid  <= valid_nxt;
            ovf    <= ovf_nxt;
        end
    end
endmodule

// File: doc/pwm_meter.md
PWM_METER -- requirements
Module: pwm_meter

Interface
REQ-001 Parameter: WIDTH, 16, width of measurement counters and outputs.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: en  input  1  measurement enable; 0 forces IDLE.
REQ-005 Port: pwm  input  1  PWM waveform under measurement; asynchronous to clk.
REQ-006 Port: period  output  WIDTH  last measured period, in clk cycles between consecutive rising edges.
REQ-007 Port: high  output  WIDTH  last measured high time, in clk cycles from rising to falling edge.
REQ-008 Port: valid  output  1  one-cycle pulse when period/high are updated.
REQ-009 Port: ovf  output  1  sticky flag: a count saturated before the edge it was waiting for arrived.

Function
REQ-010 pwm SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value for edge detection.
REQ-011 Rising edge SHALL be sync=1 with prev=0; falling edge SHALL be sync=0 with prev=1.
REQ-012 FSM states SHALL be IDLE, ARM, HIGH, LOW.
REQ-013 IDLE: when en=1, go to ARM; no counting.
REQ-014 ARM: wait for the first rising edge, discarding any partial period; on that edge go to HIGH with pcnt=1, hcnt=1.
REQ-015 HIGH: pcnt and hcnt SHALL increment each cycle; on a falling edge, freeze hcnt and go to LOW.
REQ-016 LOW: pcnt SHALL increment each cycle; on a rising edge, load period<=pcnt and high<=hcnt, pulse valid for exactly one cycle, clear ovf, then set pcnt=1, hcnt=1 and go to HIGH.
REQ-017 Counters SHALL saturate at 2^WIDTH-1 and never wrap.
REQ-018 If pcnt reaches 2^WIDTH-1 in HIGH or LOW, the block SHALL set ovf=1, go to ARM, and leave period/high unchanged. This covers constant 0% and 100% duty.
REQ-019 en=0 in any state SHALL move the FSM to IDLE on the next edge; outputs hold their values; valid=0.
REQ-020 In IDLE and ARM, valid SHALL be 0.
REQ-021 Latency: valid SHALL assert 4 clk edges after the first clk edge that samples pwm=1 following a low interval: 2 synchronizer edges, 1 detection edge, 1 output register edge.
REQ-022 Both a rising and a falling edge cannot occur in the same cycle. A 1-cycle high pulse SHALL yield high=1.
REQ-023 period and high SHALL be registered outputs; high<=period SHALL always hold on valid.

Reset
REQ-024 On rst=1 at a clk edge: FSM=IDLE, period=0, high=0, valid=0, ovf=0, pcnt=0, hcnt=0, synchronizer flops=0.
REQ-025 rst SHALL override en and any edge detected in the same cycle.
REQ-026 After rst deasserts with en=1, the first valid SHALL come only after two full rising edges have been seen: ARM, then measurement.

Verification
REQ-027 Steady pattern: en=1; pwm repeating 4 cycles high / 6 low -> second and later valid pulses give period=10, high=4, one valid per 10 cycles, ovf=0.
REQ-028 Minimum pulse: 1 high / 1 low -> period=2, high=1 on each valid.
REQ-029 Stuck level: pwm held 1 for 70000 cycles -> ovf=1 after 65535 counted cycles, no valid, period/high unchanged. A following 3/5 pattern -> valid with period=8, high=3, ovf=0.
REQ-030 Enable drop: en=0 mid-HIGH -> IDLE, no valid. Re-enable -> ARM; the first partial period is discarded.
REQ-031 Reset mid-measure: rst pulsed in LOW -> next cycle all outputs 0; measurement restarts from IDLE/ARM per REQ-026.
REQ-032 Latency check: single clean rising edge closing a period -> valid exactly 4 clk edges later, checked against REQ-021.
